// File: rtl/vga_fb_writer.sv
// vga_fb_writer: bus-to-framebuffer pixel writer with rectangle fill.
// Pixel writes queue in a small FIFO; the fill engine paints one pixel per cycle.
module vga_fb_writer #(
  parameter int HSIZE      = 800,
  parameter int VSIZE      = 600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_25M,
  input  logic        rst_n,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_data,
  output logic        bus_stall,
  output logic        busy,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [7:0]  fb_data
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, FILL} state_e;

  state_e      state_q;
  logic [11:0] x0_q, y0_q, w_q, h_q;
  logic [7:0]  color_q;
  logic [12:0] fx0_q, fy0_q, fw_q, fh_q;
  logic [12:0] cx_q, cy_q;
  logic [7:0]  fcolor_q;
  logic        busy_q, fb_we_q;
  logic [18:0] fb_addr_q;
  logic [7:0]  fb_data_q;

  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0]   cnt_q;
  logic [26:0]   mem_q [FIFO_DEPTH];

  logic        is_reg, fifo_full, fifo_empty;
  logic [1:0]  sel;
  logic        pix_req, go_req, acc;
  logic        pix_acc, pos_acc, size_acc, go_acc, go_start;
  logic        pop, bypass, push, fill_emit, clipped, wrap;
  logic [12:0] cur_x0, cur_y0, cur_w, cur_cx, cur_cy;
  logic [12:0] px, py, cx_d, cy_d;
  logic [31:0] fill_addr;
  logic [7:0]  fill_color;
  logic [26:0] head;

  assign is_reg     = bus_addr[20];
  assign sel        = bus_addr[3:2];
  assign fifo_full  = (cnt_q == FULL);
  assign fifo_empty = (cnt_q == '0);

  assign pix_req = bus_we & ~is_reg;
  assign go_req  = bus_we & is_reg & (sel == 2'd2);

  // A GO needs the engine idle and every queued pixel written first.
  assign bus_stall = (pix_req & fifo_full)
                   | (go_req & ~((state_q == IDLE) & fifo_empty));

  assign acc      = bus_we & ~bus_stall;
  assign pix_acc  = acc & ~is_reg;
  assign pos_acc  = acc & is_reg & (sel == 2'd0);
  assign size_acc = acc & is_reg & (sel == 2'd1);
  assign go_acc   = acc & is_reg & (sel == 2'd2);
  assign go_start = go_acc & (w_q != '0) & (h_q != '0);

  // An idle, empty queue forwards a new pixel straight to the outputs.
  assign pop    = (state_q == IDLE) & ~fifo_empty;
  assign bypass = pix_acc & (state_q == IDLE) & fifo_empty;
  assign push   = pix_acc & ~bypass;
  assign head   = mem_q[rp_q];

  // The GO cycle itself emits pixel (0,0), so fill latency is one cycle.
  assign fill_emit  = go_start | ((state_q == FILL) & (cy_q != fh_q));
  assign cur_x0     = go_start ? {1'b0, x0_q} : fx0_q;
  assign cur_y0     = go_start ? {1'b0, y0_q} : fy0_q;
  assign cur_w      = go_start ? {1'b0, w_q}  : fw_q;
  assign cur_cx     = go_start ? 13'd0 : cx_q;
  assign cur_cy     = go_start ? 13'd0 : cy_q;
  assign fill_color = go_start ? bus_data[7:0] : fcolor_q;

  assign px      = cur_x0 + cur_cx;
  assign py      = cur_y0 + cur_cy;
  assign clipped = ({19'd0, px} >= 32'(HSIZE))
                 | ({19'd0, py} >= 32'(VSIZE));
  assign fill_addr = {19'd0, py} * 32'(HSIZE) + {19'd0, px};

  assign wrap = ((cur_cx + 13'd1) == cur_w);
  assign cx_d = wrap ? 13'd0 : cur_cx + 13'd1;
  assign cy_d = wrap ? cur_cy + 13'd1 : cur_cy;

  logic unused_ok;
  assign unused_ok = ^{bus_addr[31:21], bus_addr[19],
                       bus_data[31:28], bus_data[15:12],
                       fill_addr[31:19]};

  // Queue storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk_25M) begin
    if (push) mem_q[wp_q] <= {bus_addr[18:0], bus_data[7:0]};
  end

  // Control FSM, fill iteration, queue pointers and registered outputs.
  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      fx0_q     <= '0;
      fy0_q     <= '0;
      fw_q      <= '0;
      fh_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      fcolor_q  <= '0;
      busy_q    <= 1'b0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
    end else begin
      fb_we_q <= 1'b0;
      if (pop) begin
        fb_we_q   <= 1'b1;
        fb_addr_q <= head[26:8];
        fb_data_q <= head[7:0];
      end else if (bypass) begin
        fb_we_q   <= 1'b1;
        fb_addr_q <= bus_addr[18:0];
        fb_data_q <= bus_data[7:0];
      end else if (fill_emit && !clipped) begin
        fb_we_q   <= 1'b1;
        fb_addr_q <= fill_addr[18:0];
        fb_data_q <= fill_color;
      end

      if (pos_acc) begin
        x0_q <= bus_data[11:0];
        y0_q <= bus_data[27:16];
      end
      if (size_acc) begin
        w_q <= bus_data[11:0];
        h_q <= bus_data[27:16];
      end
      if (go_acc) color_q <= bus_data[7:0];

      unique case (state_q)
        IDLE: begin
          if (go_start) begin
            state_q  <= FILL;
            busy_q   <= 1'b1;
            fx0_q    <= {1'b0, x0_q};
            fy0_q    <= {1'b0, y0_q};
            fw_q     <= {1'b0, w_q};
            fh_q     <= {1'b0, h_q};
            fcolor_q <= bus_data[7:0];
            cx_q     <= cx_d;
            cy_q     <= cy_d;
          end
        end
        FILL: begin
          if (cy_q == fh_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign busy    = busy_q;
  assign fb_we   = fb_we_q;
  assign fb_addr = fb_addr_q;
  assign fb_data = fb_data_q;

endmodule

// File: tb/tb_vga_fb_writer.sv
// tb_vga_fb_writer: scoreboard bench for vga_fb_writer.
// Expected framebuffer writes come from a transaction-level model.
module tb_vga_fb_writer;

  localparam int HS = 800;
  localparam int VS = 600;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_we = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_data = '0;
  logic        bus_stall, busy, fb_we;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;

  vga_fb_writer #(.HSIZE(HS), .VSIZE(VS), .FIFO_DEPTH(4)) dut (
    .clk_25M  (clk),
    .rst_n    (rst_n),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_data (bus_data),
    .bus_stall(bus_stall),
    .busy     (busy),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data)
  );

  always #20 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  logic [26:0] expq[$];
  logic [26:0] mon_e;
  int mx0 = 0, my0 = 0, mw = 0, mh = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every framebuffer write must match the next expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && fb_we === 1'b1) begin
      if (expq.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                 fb_addr, fb_data);
      end else begin
        mon_e = expq.pop_front();
        chk("fb_write", {5'd0, fb_addr, fb_data}, {5'd0, mon_e});
      end
    end
  end

  // Reference fill: row-major rectangle, off-screen pixels dropped.
  task automatic model_go(input logic [7:0] color);
    for (int y = my0; y < my0 + mh; y++)
      for (int x = mx0; x < mx0 + mw; x++)
        if (x < HS && y < VS) expq.push_back({19'(y * HS + x), color});
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    output int stalls);
    logic s;
    bit ok;
    bus_we = 1'b1;
    bus_addr = a;
    bus_data = d;
    stalls = 0;
    ok = 1'b0;
    while (!ok && stalls <= 3000) begin
      @(negedge clk);
      s = bus_stall;
      @(posedge clk);
      if (!s) ok = 1'b1;
      else stalls++;
    end
    if (!ok) begin
      vecs++;
      errs++;
      $display("FAIL accept_timeout: got stalled expected accept addr %0h", a);
    end else if (!a[20]) begin
      expq.push_back({a[18:0], d[7:0]});
    end else begin
      case (a[3:2])
        2'd0: begin mx0 = int'(d[11:0]); my0 = int'(d[27:16]); end
        2'd1: begin mw = int'(d[11:0]); mh = int'(d[27:16]); end
        2'd2: model_go(d[7:0]);
        default: ;
      endcase
    end
    #1 bus_we = 1'b0;
  endtask

  task automatic pix(input logic [18:0] a, input logic [7:0] d,
                     output int st);
    wr({$urandom() & 32'hFFE8_0000, a}, {$urandom() & 32'hFFFF_FF00, d}, st);
  endtask

  task automatic regw(input logic [1:0] sel, input logic [31:0] d,
                      output int st);
    wr(32'h0010_0000 | {28'd0, sel, 2'd0}, d, st);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int st, bc, s5[5];
  int x, y, op;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_fb_we", {31'd0, fb_we}, 0);
    chk("rst_fb_addr", {13'd0, fb_addr}, 0);
    chk("rst_fb_data", {24'd0, fb_data}, 0);
    chk("rst_stall", {31'd0, bus_stall}, 0);
    rst_n = 1'b1;
    idle(1);

    // Single pixel write: one-cycle latency, one-cycle pulse.
    pix(19'h123, 8'hE5, st);
    chk("px_we", {31'd0, fb_we}, 1);
    chk("px_addr", {13'd0, fb_addr}, 32'h123);
    chk("px_data", {24'd0, fb_data}, 32'hE5);
    idle(1);
    chk("px_we_off", {31'd0, fb_we}, 0);
    chk("px_addr_hold", {13'd0, fb_addr}, 32'h123);

    // Corner fill, partly clipped: busy for w*h cycles.
    regw(2'd0, {4'd0, 12'd599, 4'd0, 12'd798}, st);
    regw(2'd1, {4'd0, 12'd2, 4'd0, 12'd3}, st);
    regw(2'd2, 32'h1C, st);
    bc = 0;
    while (busy === 1'b1 && bc < 100) begin
      bc++;
      idle(1);
    end
    chk("corner_busy_cycles", bc, 6);
    idle(2);

    // Zero-width GO: accepted immediately, nothing happens.
    regw(2'd1, {4'd0, 12'd5, 4'd0, 12'd0}, st);
    regw(2'd2, 32'hAA, st);
    chk("zero_go_stall", st, 0);
    chk("zero_go_busy", {31'd0, busy}, 0);
    idle(4);
    chk("zero_go_busy2", {31'd0, busy}, 0);

    // Five pixels behind a 20-cycle fill: the fifth waits.
    regw(2'd0, 32'h0, st);
    regw(2'd1, {4'd0, 12'd2, 4'd0, 12'd10}, st);
    regw(2'd2, 32'h33, st);
    for (int i = 0; i < 5; i++) pix(19'(1000 + i), 8'(i + 1), s5[i]);
    for (int i = 0; i < 4; i++) chk("q_no_stall", s5[i], 0);
    chk("fifth_stalled", {31'd0, s5[4] > 0}, 1);
    chk("fifth_after_fill", {31'd0, busy}, 0);
    idle(8);

    // GO behind a non-empty queue waits for the drain.
    regw(2'd1, {4'd0, 12'd1, 4'd0, 12'd8}, st);
    regw(2'd2, 32'h44, st);
    pix(19'h50, 8'h01, st);
    pix(19'h51, 8'h02, st);
    regw(2'd2, 32'h55, st);
    chk("go_waited", {31'd0, st > 0}, 1);
    chk("go_busy_next", {31'd0, busy}, 1);
    chk("go_first_we", {31'd0, fb_we}, 1);
    idle(12);

    // Reset during a fill with two pixels queued.
    regw(2'd1, {4'd0, 12'd3, 4'd0, 12'd20}, st);
    regw(2'd2, 32'h66, st);
    pix(19'h70, 8'h07, st);
    pix(19'h71, 8'h08, st);
    idle(3);
    #5 rst_n = 1'b0;
    #1;
    chk("arst_we", {31'd0, fb_we}, 0);
    chk("arst_addr", {13'd0, fb_addr}, 0);
    chk("arst_data", {24'd0, fb_data}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    expq.delete();
    mx0 = 0; my0 = 0; mw = 0; mh = 0;
    idle(2);
    #3 rst_n = 1'b1;
    idle(40);
    chk("arst_busy_after", {31'd0, busy}, 0);

    // Randomized mix of pixels, rectangles and register rewrites.
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 99);
      if (op < 55) begin
        pix(19'($urandom()), 8'($urandom()), st);
      end else if (op < 67) begin
        case ($urandom_range(0, 2))
          0: x = $urandom_range(0, 799);
          1: x = $urandom_range(790, 805);
          default: x = $urandom_range(4088, 4095);
        endcase
        case ($urandom_range(0, 2))
          0: y = $urandom_range(0, 599);
          1: y = $urandom_range(594, 603);
          default: y = $urandom_range(4090, 4095);
        endcase
        regw(2'd0, {4'hF, 12'(y), 4'hA, 12'(x)}, st);
      end else if (op < 79) begin
        regw(2'd1, {4'h5, 12'($urandom_range(0, 4)), 4'h3,
                    12'($urandom_range(0, 7))}, st);
      end else if (op < 94) begin
        regw(2'd2, $urandom(), st);
      end else begin
        regw(2'd3, $urandom(), st);
        chk("sel3_no_stall", st, 0);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
    end

    bc = 0;
    while ((expq.size() != 0 || busy === 1'b1) && bc < 3000) begin
      bc++;
      idle(1);
    end
    idle(6);
    chk("queue_drained", expq.size(), 0);
    chk("final_busy", {31'd0, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/vga_fb_writer.md
VGA_FB_WRITER -- requirements
Module: vga_fb_writer

Interface
REQ-001 Parameter HSIZE, default 800, visible pixels per line; framebuffer address stride.
REQ-002 Parameter VSIZE, default 600, visible lines.
REQ-003 Parameter FIFO_DEPTH, default 4, pixel-write queue entries (power of 2, >=2).
REQ-004 clk_25M  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 bus_we  input  1  bus write strobe, 1 = valid request.
REQ-007 bus_addr  input  32  write address.
REQ-008 bus_data  input  32  write data.
REQ-009 bus_stall  output  1  combinational; 1 = request not accepted, bus holds it.
REQ-010 busy  output  1  registered; 1 = fill engine active.
REQ-011 fb_we  output  1  registered framebuffer write enable.
REQ-012 fb_addr  output  19  registered pixel index, y*HSIZE+x.
REQ-013 fb_data  output  8  registered pixel {B[1:0],G[2:0],R[2:0]}.

Function
REQ-014 Accept = bus_we & !bus_stall; requests with bus_stall=1 have no effect.
REQ-015 bus_addr[20]=0: pixel write; push {bus_addr[18:0], bus_data[7:0]} into FIFO.
REQ-016 bus_addr[20]=1: register write, select bus_addr[3:2]: 0 FILL_POS (x0=data[11:0], y0=data[27:16]); 1 FILL_SIZE (w=data[11:0], h=data[27:16]); 2 FILL_GO (color=data[7:0], start fill); 3 ignored, never stalls.
REQ-017 bus_stall=1 for pixel write when FIFO count==FIFO_DEPTH (no same-cycle pop credit).
REQ-018 bus_stall=1 for FILL_GO unless state IDLE and FIFO empty; FILL_POS/FILL_SIZE never stall and may be rewritten during FILL without affecting the running fill.
REQ-019 FSM states IDLE, FILL; IDLE->FILL on accepted FILL_GO with w!=0 and h!=0; FILL->IDLE after last pixel cycle.
REQ-020 FILL_GO with w==0 or h==0: accepted, stays IDLE, no fb writes, busy stays 0.
REQ-021 Fill latches x0,y0,w,h,color at GO; emits one pixel per cycle, x from x0 to x0+w-1 inner, y from y0 to y0+h-1 outer.
REQ-022 Fill pixel with x>=HSIZE or y>=VSIZE: fb_we=0 that cycle, iteration still advances (clipped, cycle count unchanged).
REQ-023 Coordinate arithmetic 13-bit unsigned; no wrap of x0+w or y0+h into visible range.
REQ-024 GO accepted cycle N: busy=1 and first fill write on fb outputs cycles N+1..N+w*h; busy=0 at N+w*h+1.
REQ-025 In IDLE, FIFO pops one entry per cycle when non-empty; entry accepted cycle N into empty FIFO appears on fb outputs cycle N+1.
REQ-026 In FILL, FIFO never pops; accepted pixel writes queue and drain in order after FILL->IDLE.
REQ-027 Simultaneous push and pop on a non-full FIFO: both take effect, count unchanged.
REQ-028 fb_we=0 on any cycle with no pop and no unclipped fill pixel; fb_addr/fb_data hold last value.

Reset
REQ-029 rst_n=0 asynchronously forces: state IDLE, FIFO empty, busy=0, fb_we=0, fb_addr=0, fb_data=0, x0=y0=w=h=color=0.
REQ-030 Reset mid-FILL aborts the fill and discards queued FIFO entries; no write after rst_n deasserts until a new request.

Verification
REQ-031 Pixel write addr 0x00000123 data 0xE5 -> next cycle fb_we=1, fb_addr=0x123, fb_data=0xE5; following cycle fb_we=0.
REQ-032 Five back-to-back pixel writes during FILL, FIFO_DEPTH=4 -> 5th sees bus_stall=1 until FILL ends; all five emerge in order afterwards.
REQ-033 POS x0=798,y0=599; SIZE w=3,h=2; GO color 0x1C -> busy 6 cycles; writes only at addr 599*800+798 and 599*800+799.
REQ-034 GO with w=0,h=5 -> no stall, busy=0, no fb_we.
REQ-035 rst_n low mid-fill with 2 entries queued -> outputs zero immediately; no fb_we after release.
REQ-036 GO issued with FIFO non-empty -> bus_stall=1 until FIFO drains, fill starts next cycle after acceptance.
